// File: rtl/elm_output_mac_engine_pkg.sv
// Shared types and helpers for the ELM output-layer MAC engine.
// Holds default formats, the control state encoding, and the accumulator width and clamp helpers.
package elm_pkg;

    localparam int ELM_DATA_W = 21;
    localparam int ELM_FRAC_W = 10;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    // Wide enough that neither a rescaled product nor an N_HIDDEN-term sum can wrap.
    function automatic int acc_width(input int data_w, input int frac_w, input int n_hidden);
        return 2 * data_w - frac_w + $clog2(n_hidden) + 1;
    endfunction

    function automatic logic signed [63:0] sat_to_data_w(input logic signed [63:0] acc,
                                                        input int data_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (data_w - 1));
        if (acc > hi) begin
            return hi;
        end
        if (acc < lo) begin
            return lo;
        end
        return acc;
    endfunction

endpackage

// File: rtl/elm_output_mac_engine_if.sv
// Activation stream, weight ROM port and result bus of the output MAC engine.
interface elm_output_mac_engine_if #(
    parameter int DATA_W = 21,
    parameter int N_OUT  = 10,
    parameter int ADDR_W = 9,
    parameter int IDX_W  = 4
);
    logic                       start;
    logic signed [DATA_W-1:0]   h_data;
    logic                       h_valid;
    logic                       h_ready;
    logic [ADDR_W-1:0]          w_addr;
    logic [N_OUT*DATA_W-1:0]    w_data;
    logic [N_OUT*DATA_W-1:0]    y_flat;
    logic [N_OUT-1:0]           y_sat;
    logic [IDX_W-1:0]           class_idx;
    logic                       done;
    logic                       busy;

    modport master (
        output start, h_data, h_valid, w_data,
        input  h_ready, w_addr, y_flat, y_sat, class_idx, done, busy
    );

    modport slave (
        input  start, h_data, h_valid, w_data,
        output h_ready, w_addr, y_flat, y_sat, class_idx, done, busy
    );
endinterface

// File: rtl/elm_output_mac_engine_mac_lane.sv
// One output node: multiply, rescale by FRAC_W (floor), accumulate, then clamp to DATA_W.
module elm_mac_lane
    import elm_pkg::*;
#(
    parameter int DATA_W = ELM_DATA_W,
    parameter int FRAC_W = ELM_FRAC_W,
    parameter int ACC_W  = 42
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic                     finalize,
    input  logic signed [DATA_W-1:0] h_q,
    input  logic signed [DATA_W-1:0] w,
    output logic signed [DATA_W-1:0] y,
    output logic signed [DATA_W-1:0] y_next,
    output logic                     y_sat
);
    logic signed [2*DATA_W-1:0] full_prod;
    logic signed [ACC_W-1:0]    prod_next;
    logic signed [ACC_W-1:0]    prod_reg;
    logic                       prod_v_reg;
    logic signed [ACC_W-1:0]    acc_reg;
    logic signed [63:0]         acc_ext;
    logic signed [63:0]         sat_ext;
    logic                       sat_next;

    assign full_prod = h_q * w;
    assign prod_next = ACC_W'(full_prod >>> FRAC_W);

    assign acc_ext  = 64'(acc_reg);
    assign sat_ext  = sat_to_data_w(acc_ext, DATA_W);
    assign sat_next = (sat_ext != acc_ext);
    assign y_next   = sat_ext[DATA_W-1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            prod_reg   <= '0;
            prod_v_reg <= 1'b0;
            acc_reg    <= '0;
            y          <= '0;
            y_sat      <= 1'b0;
        end else begin
            prod_v_reg <= in_valid;
            if (in_valid) begin
                prod_reg <= prod_next;
            end
            // Bubbles never reach the accumulator; only tagged products are summed.
            if (clear) begin
                acc_reg <= '0;
            end else if (prod_v_reg) begin
                acc_reg <= acc_reg + prod_reg;
            end
            if (finalize) begin
                y     <= y_next;
                y_sat <= sat_next;
            end
        end
    end

endmodule

// File: rtl/elm_output_mac_engine.sv
// Output-layer engine: streams N_HIDDEN activations against a weight ROM into N_OUT MAC lanes,
// then publishes saturated outputs, per-lane saturation flags and the argmax class together with done.
module elm_output_mac_engine
    import elm_pkg::*;
#(
    parameter int DATA_W   = ELM_DATA_W,
    parameter int FRAC_W   = ELM_FRAC_W,
    parameter int N_HIDDEN = 300,
    parameter int N_OUT    = 10,
    parameter int ADDR_W   = $clog2(N_HIDDEN),
    parameter int IDX_W    = $clog2(N_OUT)
) (
    input logic                    clock,
    input logic                    reset,
    elm_output_mac_engine_if.slave bus
);
    localparam int                ACC_W     = acc_width(DATA_W, FRAC_W, N_HIDDEN);
    localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(N_HIDDEN - 1);

    state_t                   state_reg;
    state_t                   state_next;
    logic [ADDR_W-1:0]        beat_reg;
    logic [ADDR_W-1:0]        beat_next;
    logic [1:0]               drain_reg;
    logic [1:0]               drain_next;
    logic signed [DATA_W-1:0] h_q_reg;
    logic                     v1_reg;
    logic                     done_reg;
    logic [IDX_W-1:0]         class_idx_reg;
    logic                     accept;
    logic                     clear;
    logic                     finalize;

    logic signed [DATA_W-1:0] y_arr      [N_OUT];
    logic signed [DATA_W-1:0] y_next_arr [N_OUT];
    logic [N_OUT-1:0]         y_sat_vec;
    logic [IDX_W-1:0]         best_idx;
    logic signed [DATA_W-1:0] best_val;

    always_comb begin
        state_next = state_reg;
        beat_next  = beat_reg;
        drain_next = drain_reg;
        accept     = 1'b0;
        clear      = 1'b0;
        finalize   = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = RUN;
                    beat_next  = '0;
                    clear      = 1'b1;
                end
            end
            RUN: begin
                if (bus.h_valid) begin
                    accept = 1'b1;
                    if (beat_reg == LAST_BEAT) begin
                        state_next = DRAIN;
                        beat_next  = '0;
                        drain_next = '0;
                    end else begin
                        beat_next = beat_reg + ADDR_W'(1);
                    end
                end
            end
            DRAIN: begin
                // Three drain cycles cover the h_q, product and accumulate stages.
                if (drain_reg == 2'd2) begin
                    state_next = IDLE;
                    finalize   = 1'b1;
                end else begin
                    drain_next = drain_reg + 2'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            beat_reg      <= '0;
            drain_reg     <= '0;
            h_q_reg       <= '0;
            v1_reg        <= 1'b0;
            done_reg      <= 1'b0;
            class_idx_reg <= '0;
        end else begin
            state_reg <= state_next;
            beat_reg  <= beat_next;
            drain_reg <= drain_next;
            v1_reg    <= accept;
            done_reg  <= finalize;
            if (accept) begin
                h_q_reg <= bus.h_data;
            end
            if (finalize) begin
                class_idx_reg <= best_idx;
            end
        end
    end

    // The beat counter doubles as the ROM address so row i is already in flight when beat i is accepted.
    assign bus.w_addr    = beat_reg;
    assign bus.h_ready   = (state_reg == RUN);
    assign bus.busy      = (state_reg != IDLE);
    assign bus.done      = done_reg;
    assign bus.class_idx = class_idx_reg;
    assign bus.y_sat     = y_sat_vec;

    generate
        for (genvar gi = 0; gi < N_OUT; gi++) begin : g_lane
            elm_mac_lane #(
                .DATA_W (DATA_W),
                .FRAC_W (FRAC_W),
                .ACC_W  (ACC_W)
            ) u_lane (
                .clock    (clock),
                .reset    (reset),
                .clear    (clear),
                .in_valid (v1_reg),
                .finalize (finalize),
                .h_q      (h_q_reg),
                .w        (bus.w_data[gi*DATA_W +: DATA_W]),
                .y        (y_arr[gi]),
                .y_next   (y_next_arr[gi]),
                .y_sat    (y_sat_vec[gi])
            );
            assign bus.y_flat[gi*DATA_W +: DATA_W] = y_arr[gi];
        end
    endgenerate

    // Argmax over the clamped values; strict compare keeps the lowest index on ties.
    always_comb begin
        best_idx = '0;
        best_val = y_next_arr[0];
        for (int k = 1; k < N_OUT; k++) begin
            if (y_next_arr[k] > best_val) begin
                best_val = y_next_arr[k];
                best_idx = IDX_W'(k);
            end
        end
    end

endmodule
